light_sequencer: RTL
====================

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter MAIN_GREEN_BASE, default 20, giving the base main-road green length in ticks.
REQ-002 SHALL have parameter MIN_MAIN_GREEN, default 10, giving the minimum main green length in ticks before a country request may end it.
REQ-003 SHALL have parameter COUNTRY_GREEN_T, default 15, giving the country-road green length in ticks.
REQ-004 SHALL have parameter YELLOW_T, default 3, giving the yellow length in ticks for either road.
REQ-005 SHALL have parameter ALL_RED_T, default 2, giving the all-red clearance length in ticks.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-007 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port TICK, input, 1 bit: one-cycle timing strobe; phase timers advance only in cycles where TICK=1.
REQ-009 SHALL have port COUNTRY_PULSE, input, 1 bit: one-cycle country-road service request from the controller.
REQ-010 SHALL have port LIGHT_RANK, input, 5 bits: traffic rank for the current hour; higher means a longer main green.
REQ-011 SHALL have port MAIN_LIGHT, output, 3 bits: main-road lamps, registered, with bit0=green, bit1=yellow, bit2=red.
REQ-012 SHALL have port COUNTRY_LIGHT, output, 3 bits: country-road lamps, registered, using the same bit encoding as MAIN_LIGHT.
REQ-013 SHALL have port CYCLE_DONE, output, 1 bit: one-cycle pulse on re-entry to MAIN_GREEN.

Function
REQ-014 SHALL implement FSM states MAIN_GREEN, MAIN_YELLOW, RED_TO_COUNTRY, COUNTRY_GREEN, COUNTRY_YELLOW and RED_TO_MAIN, which transition cyclically in that order.
REQ-015 SHALL use a 7-bit up-counter CNT that clears on every state entry and increments on TICK.
REQ-016 SHALL leave a state on the TICK where CNT equals the state length minus 1; the new state and lamps take effect at that same clock edge.
REQ-017 SHALL latch GREEN_LEN = MAIN_GREEN_BASE + LIGHT_RANK on entry to MAIN_GREEN, saturating at 127; LIGHT_RANK changes during MAIN_GREEN SHALL be ignored.
REQ-018 SHALL set a PENDING flag when COUNTRY_PULSE=1 in MAIN_GREEN or MAIN_YELLOW; pulses in all other states SHALL be dropped.
REQ-019 SHALL, in MAIN_GREEN, leave early to MAIN_YELLOW on a TICK where PENDING=1 and CNT+1 >= MIN_MAIN_GREEN.
REQ-020 SHALL treat a COUNTRY_PULSE in the same cycle as a qualifying TICK as pending, so the early exit is taken at that edge.
REQ-021 SHALL clear PENDING on entry to COUNTRY_GREEN.
REQ-022 SHALL drive the following lamps:
  - MAIN_GREEN: MAIN=001, COUNTRY=100
  - MAIN_YELLOW: MAIN=010, COUNTRY=100
  - COUNTRY_GREEN: MAIN=100, COUNTRY=001
  - COUNTRY_YELLOW: MAIN=100, COUNTRY=010
  - RED_TO_COUNTRY and RED_TO_MAIN: both 100
REQ-023 SHALL never assert green on both roads, and SHALL never hold more than one bit of either lamp output high.
REQ-024 SHALL assert CYCLE_DONE for exactly one cycle on the RED_TO_MAIN to MAIN_GREEN edge.
REQ-025 SHALL hold all state while TICK=0, apart from PENDING capture.

Reset
REQ-026 SHALL, while RESET=1, immediately set:
  - state = MAIN_GREEN
  - MAIN_LIGHT = 001, COUNTRY_LIGHT = 100
  - CYCLE_DONE = 0, PENDING = 0, CNT = 0
  - GREEN_LEN = MAIN_GREEN_BASE
REQ-027 SHALL abandon any phase in progress when RESET is asserted mid-phase, with no yellow or all-red sequencing.
REQ-028 SHALL restart timing from CNT=0 on the first TICK after RESET deasserts.

Structure
REQ-029 SHALL take the LIGHT_STATE enum and the lamp encodings GREEN=001, YELLOW=010, RED=100 from the shared package TRAFFIC_PKG.
REQ-030 SHALL implement CNT in one sub-module, LIGHT_TIMER, with inputs CLK, RESET, TICK, CLEAR and output CNT[6:0].

Verification
REQ-031 SHALL cover: LIGHT_RANK=5, no pulse -> MAIN green 25 ticks, yellow 3, all-red 2, country green 15, yellow 3, all-red 2; CYCLE_DONE pulses once.
REQ-032 SHALL cover: COUNTRY_PULSE at tick 4 of MAIN_GREEN -> MAIN_YELLOW entered at the edge of tick 10.
REQ-033 SHALL cover: COUNTRY_PULSE at tick 12 -> MAIN_YELLOW on that same TICK edge.
REQ-034 SHALL cover: pulse during COUNTRY_GREEN -> dropped; the next MAIN_GREEN lasts the full GREEN_LEN.
REQ-035 SHALL cover: LIGHT_RANK=31 with MAIN_GREEN_BASE=120 -> GREEN_LEN=127.
REQ-036 SHALL cover: RESET asserted mid-COUNTRY_GREEN -> MAIN=001 and COUNTRY=100 before the next CLK edge; an assertion checks that both roads are never green together.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light sequencer.
//   light_state_e   : sequencer phase, visited cyclically in declaration order
//   Lamp*           : one-hot lamp encodings (bit0 green, bit1 yellow, bit2 red)
//   GreenLenMax     : ceiling for the latched main-road green length
//   sat_green_len() : base + rank, saturated at GreenLenMax
package traffic_pkg;

  typedef enum logic [2:0] {
    StMainGreen,
    StMainYellow,
    StRedToCountry,
    StCountryGreen,
    StCountryYellow,
    StRedToMain
  } light_state_e;

  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampRed    = 3'b100;

  localparam int unsigned GreenLenMax = 127;

  function automatic logic [6:0] sat_green_len(input int unsigned base, input logic [4:0] rank);
    int unsigned sum;
    sum = base + {27'd0, rank};
    return (sum > GreenLenMax) ? 7'(GreenLenMax) : sum[6:0];
  endfunction

endpackage

// File: rtl/light_timer.sv
// Phase tick counter for the light sequencer.
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset, clears the count
//   TICK  : count enable strobe
//   CLEAR : restart from zero (phase entry); wins over TICK
//   CNT   : current tick count within the phase
module light_timer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       CLEAR,
  output logic [6:0] CNT
);

  logic [6:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLEAR) begin
      cnt_d = '0;
    end else if (TICK) begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/light_sequencer.sv
// Main-road / country-road traffic light sequencer.
//   CLK           : clock, rising edge
//   RESET         : asynchronous active-high reset, forces main green immediately
//   TICK          : timing strobe; phase timers only advance when high
//   COUNTRY_PULSE : country-road service request (one cycle)
//   LIGHT_RANK    : traffic rank, extends main green when latched at its entry
//   MAIN_LIGHT    : registered main-road lamps  (bit0 green, bit1 yellow, bit2 red)
//   COUNTRY_LIGHT : registered country-road lamps, same encoding
//   CYCLE_DONE    : one-cycle pulse on re-entry to main green
module light_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned MAIN_GREEN_BASE = 20,
  parameter int unsigned MIN_MAIN_GREEN  = 10,
  parameter int unsigned COUNTRY_GREEN_T = 15,
  parameter int unsigned YELLOW_T        = 3,
  parameter int unsigned ALL_RED_T       = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       COUNTRY_PULSE,
  input  logic [4:0] LIGHT_RANK,
  output logic [2:0] MAIN_LIGHT,
  output logic [2:0] COUNTRY_LIGHT,
  output logic       CYCLE_DONE
);

  light_state_e state_q, state_d;
  logic [6:0]   cnt;
  logic [6:0]   last_cnt;
  logic [6:0]   green_len_q, green_len_d;
  logic         pending_q, pending_d;
  logic [2:0]   main_q, main_d, country_q, country_d;
  logic         cycle_done_q, cycle_done_d;
  logic         pulse_ok, pend_now, early_exit, state_change;

  light_timer u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (TICK),
    .CLEAR (state_change),
    .CNT   (cnt)
  );

  // Requests only count while the main road still has right of way.
  assign pulse_ok = COUNTRY_PULSE && (state_q == StMainGreen || state_q == StMainYellow);
  // A request arriving with the qualifying tick takes effect at that same edge.
  assign pend_now = pending_q | pulse_ok;

  always_comb begin
    unique case (state_q)
      StMainGreen:                     last_cnt = green_len_q - 7'd1;
      StMainYellow, StCountryYellow:   last_cnt = 7'(YELLOW_T - 1);
      StRedToCountry, StRedToMain:     last_cnt = 7'(ALL_RED_T - 1);
      StCountryGreen:                  last_cnt = 7'(COUNTRY_GREEN_T - 1);
      default:                         last_cnt = '0;
    endcase
  end

  assign early_exit   = (state_q == StMainGreen) && pend_now &&
                        (32'(cnt) + 32'd1 >= MIN_MAIN_GREEN);
  assign state_change = TICK && ((cnt == last_cnt) || early_exit);

  // Next state and side-state updates.
  always_comb begin
    state_d      = state_q;
    green_len_d  = green_len_q;
    pending_d    = pend_now;
    cycle_done_d = 1'b0;
    if (state_change) begin
      unique case (state_q)
        StMainGreen:     state_d = StMainYellow;
        StMainYellow:    state_d = StRedToCountry;
        StRedToCountry:  begin
          state_d   = StCountryGreen;
          pending_d = 1'b0;
        end
        StCountryGreen:  state_d = StCountryYellow;
        StCountryYellow: state_d = StRedToMain;
        StRedToMain:     begin
          state_d      = StMainGreen;
          green_len_d  = sat_green_len(MAIN_GREEN_BASE, LIGHT_RANK);
          cycle_done_d = 1'b1;
        end
        default:         state_d = StMainGreen;
      endcase
    end
  end

  // Lamps are decoded from the next state so they change at the same edge as the state.
  always_comb begin
    main_d    = LampRed;
    country_d = LampRed;
    unique case (state_d)
      StMainGreen:     main_d    = LampGreen;
      StMainYellow:    main_d    = LampYellow;
      StCountryGreen:  country_d = LampGreen;
      StCountryYellow: country_d = LampYellow;
      default:         ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StMainGreen;
      green_len_q  <= sat_green_len(MAIN_GREEN_BASE, 5'd0);
      pending_q    <= 1'b0;
      main_q       <= LampGreen;
      country_q    <= LampRed;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      green_len_q  <= green_len_d;
      pending_q    <= pending_d;
      main_q       <= main_d;
      country_q    <= country_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign MAIN_LIGHT    = main_q;
  assign COUNTRY_LIGHT = country_q;
  assign CYCLE_DONE    = cycle_done_q;

endmodule
